// File: rtl/sram_pkg.sv
// Shared types and sizing helpers for the Wishbone-to-async-SRAM bridge.
package sram_pkg;

  // Phases of one SRAM cycle; IDLE doubles as the completion/ack clock.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  // Largest of the three phase lengths, used to size the shared down-counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width: enough bits to hold the longest phase length.
  function automatic int cnt_width(input int max_cycles);
    return $clog2(max_cycles) + 1;
  endfunction

endpackage

// File: rtl/sram_wb_bridge.sv
// Wishbone pipelined slave driving a timed asynchronous SRAM read/write
// cycle. One transaction in flight; every output comes straight from a flop.
module sram_wb_bridge
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 17,
  parameter int SETUP_CYCLES  = 1,
  parameter int ACCESS_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  wb_clock_i,
  input  logic                  wb_reset_ni,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  wb_we_i,
  input  logic                  wb_cycle_i,
  input  logic                  wb_strobe_i,
  output logic                  wb_stall_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_oe_o,
  output logic                  ram_we_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_data_oe
);

  // A zero-length strobe would produce no OE/WE pulse at all.
  if (ACCESS_CYCLES < 1) begin : g_bad_access
    $error("sram_wb_bridge: ACCESS_CYCLES must be at least 1");
  end

  localparam int CNT_W = cnt_width(max3(SETUP_CYCLES, ACCESS_CYCLES, HOLD_CYCLES));

  // Counter reload values: each phase runs for (load + 1) clocks.
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'((SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] ACCESS_LOAD = CNT_W'((ACCESS_CYCLES > 0) ? ACCESS_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic                  stall_q;
  logic                  ack_q;
  logic                  oe_q;
  logic                  wen_q;
  logic                  doe_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Sequencer: phase FSM, shared down-counter and all registered pin drivers.
  // NOTE: the async reset is in the sensitivity list so a mid-cycle reset
  // releases WE/OE/data pins immediately, without waiting for a clock edge.
  always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      wen_q   <= 1'b0;
      doe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the pre-edge values of its neighbours regardless of order.
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          stall_q <= 1'b0;
          doe_q   <= 1'b0;
          if (wb_cycle_i && wb_strobe_i) begin
            we_q    <= wb_we_i;
            addr_q  <= wb_addr_i;
            wdata_q <= wb_data_i;
            stall_q <= 1'b1;
            doe_q   <= wb_we_i;
            if (SETUP_CYCLES > 0) begin
              state_q <= SETUP;
              cnt_q   <= SETUP_LOAD;
            end else begin
              state_q <= ACCESS;
              cnt_q   <= ACCESS_LOAD;
              oe_q    <= !wb_we_i;
              wen_q   <= wb_we_i;
            end
          end
        end

        SETUP: begin
          if (cnt_q == '0) begin
            state_q <= ACCESS;
            cnt_q   <= ACCESS_LOAD;
            oe_q    <= !we_q;
            wen_q   <= we_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ACCESS: begin
          if (cnt_q == '0) begin
            oe_q  <= 1'b0;
            wen_q <= 1'b0;
            // Sample the pins on the edge that ends the strobe, OE still high.
            if (!we_q) begin
              rdata_q <= ram_data_i;
            end
            if (HOLD_CYCLES > 0) begin
              state_q <= HOLD;
              cnt_q   <= HOLD_LOAD;
            end else begin
              state_q <= IDLE;
              stall_q <= 1'b0;
              ack_q   <= wb_cycle_i;
              doe_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
            ack_q   <= wb_cycle_i;
            doe_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
          oe_q    <= 1'b0;
          wen_q   <= 1'b0;
          doe_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wb_data_o   = rdata_q;
  assign wb_stall_o  = stall_q;
  assign wb_ack_o    = ack_q;
  assign ram_addr_o  = addr_q;
  assign ram_oe_o    = oe_q;
  assign ram_we_o    = wen_q;
  assign ram_data_o  = wdata_q;
  assign ram_data_oe = doe_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Self-checking bench for sram_wb_bridge: default-timing instance with an
// SRAM model and scoreboard, plus a zero-setup/hold instance.
module tb_sram_wb_bridge;

  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-timing instance
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_wdata, wb_rdata;
  logic wb_we, wb_cyc, wb_stb, wb_stall, wb_ack;
  logic [AW-1:0] ram_addr;
  logic ram_oe, ram_we, ram_doe;
  logic [DW-1:0] ram_din, ram_dout;

  sram_wb_bridge dut (
    .wb_clock_i (clk),      .wb_reset_ni(rst_n),
    .wb_addr_i  (wb_addr),  .wb_data_i  (wb_wdata), .wb_data_o(wb_rdata),
    .wb_we_i    (wb_we),    .wb_cycle_i (wb_cyc),   .wb_strobe_i(wb_stb),
    .wb_stall_o (wb_stall), .wb_ack_o   (wb_ack),
    .ram_addr_o (ram_addr), .ram_oe_o   (ram_oe),   .ram_we_o (ram_we),
    .ram_data_i (ram_din),  .ram_data_o (ram_dout), .ram_data_oe(ram_doe)
  );

  // Zero setup/hold instance
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_wdata, z_rdata;
  logic z_we, z_cyc, z_stb, z_stall, z_ack;
  logic [AW-1:0] z_raddr;
  logic z_oe, z_rwe, z_doe;
  logic [DW-1:0] z_din, z_dout;

  sram_wb_bridge #(.SETUP_CYCLES(0), .ACCESS_CYCLES(2), .HOLD_CYCLES(0)) dut_z (
    .wb_clock_i (clk),     .wb_reset_ni(rst_n),
    .wb_addr_i  (z_addr),  .wb_data_i  (z_wdata), .wb_data_o(z_rdata),
    .wb_we_i    (z_we),    .wb_cycle_i (z_cyc),   .wb_strobe_i(z_stb),
    .wb_stall_o (z_stall), .wb_ack_o   (z_ack),
    .ram_addr_o (z_raddr), .ram_oe_o   (z_oe),    .ram_we_o (z_rwe),
    .ram_data_i (z_din),   .ram_data_o (z_dout),  .ram_data_oe(z_doe)
  );

  // Async SRAM models: default instance has a real array, the other a pattern.
  logic [DW-1:0] mem [0:131071];
  assign ram_din = ram_oe ? mem[ram_addr] : 8'h00;
  assign z_din   = z_oe ? (z_raddr[7:0] ^ 8'h5A) : 8'h00;

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h1_2345] = 8'hA5;
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] = ram_dout;
    end
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit            is_read;
    logic [DW-1:0] data;
    int            acc;
  } sb_t;
  sb_t sb[$];

  int last_acc;
  int ack_cnt = 0;
  int oe_run = 0, we_run = 0, doe_run = 0;
  int oe_len = 0, we_len = 0, doe_len = 0;
  bit doe_seen = 0;
  bit stall_prev = 0;
  logic [AW-1:0] addr_prev = '0;

  // Monitor: invariants, ack/stall relation, scoreboard, pulse widths.
  initial begin
    sb_t it;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        oe_run = 0; we_run = 0; doe_run = 0; stall_prev = 0;
        continue;
      end
      check("inv_oe_we",  {31'd0, ram_oe & ram_we}, 0);
      check("inv_we_doe", {31'd0, ram_we & !ram_doe}, 0);
      check("inv_oe_doe", {31'd0, ram_oe & ram_doe}, 0);
      if (wb_stall && stall_prev) check("addr_stable", ram_addr, addr_prev);
      check("ack_pulse", wb_ack, stall_prev & !wb_stall & wb_cyc);
      if (wb_ack) begin
        ack_cnt++;
        if (sb.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          it = sb.pop_front();
          check("ack_latency", edge_n - it.acc, 6);
          if (it.is_read) check("rdata", wb_rdata, it.data);
        end
      end
      if (ram_doe) doe_seen = 1;
      if (ram_oe) oe_run++;   else if (oe_run  != 0) begin oe_len  = oe_run;  oe_run  = 0; end
      if (ram_we) we_run++;   else if (we_run  != 0) begin we_len  = we_run;  we_run  = 0; end
      if (ram_doe) doe_run++; else if (doe_run != 0) begin doe_len = doe_run; doe_run = 0; end
      stall_prev = wb_stall;
      addr_prev  = ram_addr;
    end
  end

  // Present a request (strobe stays high) and record its acceptance edge.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (wb_stall && n < 30) begin @(negedge clk); n++; end
    if (wb_stall) check("issue_timeout", 1, 0);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
    @(posedge clk); #1;
    last_acc = edge_n;
    sb.push_back('{is_read: !we, data: d, acc: edge_n});
  endtask

  task automatic bus_idle();
    wb_stb = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || wb_stall) && n < 50) begin @(negedge clk); n++; end
    if (sb.size() != 0 || wb_stall) check("done_timeout", 1, 0);
  endtask

  task automatic wait_we();
    int n = 0;
    while (!ram_we && n < 20) begin @(negedge clk); n++; end
    check("we_seen", {31'd0, ram_we}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, a3, acks0, zk, n, zoe;
    bit got;
    wb_addr = '0; wb_wdata = '0; wb_we = 0; wb_cyc = 0; wb_stb = 0;
    z_addr = '0; z_wdata = '0; z_we = 0; z_cyc = 0; z_stb = 0;
    repeat (3) @(negedge clk);
    check("rst_stall", wb_stall, 0);
    check("rst_ack",   wb_ack,   0);
    check("rst_oe",    ram_oe,   0);
    check("rst_we",    ram_we,   0);
    check("rst_doe",   ram_doe,  0);
    check("rst_addr",  ram_addr, 0);
    check("rst_dout",  ram_dout, 0);
    check("rst_rdata", wb_rdata, 0);
    rst_n = 1'b1;

    // Read with default timing
    doe_seen = 0;
    issue(0, 17'h1_2345, 8'hA5);
    bus_idle();
    wait_done();
    check("rd_oe_len", oe_len, 4);
    check("rd_doe_never", {31'd0, doe_seen}, 0);
    check("rd_hold_data", wb_rdata, 8'hA5);

    // Write, then read back
    issue(1, 17'h0_8000, 8'h3C);
    bus_idle();
    wait_done();
    check("wr_doe_len", doe_len, 6);
    check("wr_we_len", we_len, 4);
    check("wr_mem", mem[17'h0_8000], 8'h3C);
    check("wr_keeps_rdata", wb_rdata, 8'hA5);
    issue(0, 17'h0_8000, 8'h3C);
    bus_idle();
    wait_done();

    // Back-to-back with strobe held high
    issue(1, 17'h0_0010, 8'h11); a1 = last_acc;
    issue(0, 17'h0_0010, 8'h11); a2 = last_acc;
    issue(1, 17'h0_0011, 8'h22); a3 = last_acc;
    bus_idle();
    wait_done();
    check("b2b_gap1", a2 - a1, 7);
    check("b2b_gap2", a3 - a2, 7);
    check("b2b_mem", mem[17'h0_0011], 8'h22);
    wb_cyc = 1'b0;

    // Zero setup/hold instance, ACCESS=2
    @(negedge clk);
    z_cyc = 1; z_stb = 1; z_we = 0; z_addr = 17'h0_0123;
    @(posedge clk); #1;
    zk = edge_n; z_stb = 0;
    n = 0; zoe = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      if (z_oe) zoe++;
      if (z_ack) begin
        got = 1;
        check("z_latency", edge_n - zk, 2);
        check("z_rdata", z_rdata, 8'h79);
      end
    end
    check("z_ack_seen", {31'd0, got}, 1);
    check("z_oe_len", zoe, 2);
    z_cyc = 0;

    // Cycle dropped during ACCESS of a write
    acks0 = ack_cnt;
    issue(1, 17'h0_0200, 8'h77);
    void'(sb.pop_back());
    bus_idle();
    wait_we();
    wb_cyc = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    check("drop_we_len", we_len, 4);
    check("drop_mem", mem[17'h0_0200], 8'h77);
    check("drop_no_ack", ack_cnt, acks0);
    issue(0, 17'h0_0200, 8'h77);
    bus_idle();
    wait_done();

    // Reset asserted during ACCESS of a write
    acks0 = ack_cnt;
    issue(1, 17'h0_0300, 8'h99);
    bus_idle();
    wait_we();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rstw_we",    ram_we,   0);
    check("rstw_doe",   ram_doe,  0);
    check("rstw_stall", wb_stall, 0);
    check("rstw_ack",   wb_ack,   0);
    check("rstw_rdata", wb_rdata, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("rstw_no_ack", ack_cnt, acks0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_idle_stall", wb_stall, 0);
    check("rstw_idle_oe", ram_oe, 0);
    issue(0, 17'h1_2345, 8'hA5);
    bus_idle();
    wait_done();
    check("rstw_read", wb_rdata, 8'hA5);
    wb_cyc = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
